// File: rtl/uart_frame_deframer.sv
// ---------------------------------------------------------------------------
// uart_frame_deframer
//
// Pulls bytes out of the uart rx FIFO (first-word fall-through read port) and
// extracts framed packets of the form SYNC, LEN, LEN payload bytes, CHK.
// Payload bytes leave as a valid/ready byte stream with a last marker, and
// every finished or aborted frame produces a one-cycle status pulse.
//
// The checksum byte is chosen so that LEN + payload + CHK == 0 (mod 256).
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   ce         in   clock enable for the inter-byte timeout counter only
//   rx_data    in   FIFO head word, valid while rx_empty is low
//   rx_empty   in   FIFO empty flag
//   rx_read    out  registered one-cycle pop pulse to the FIFO
//   out_data   out  payload byte
//   out_valid  out  out_data valid, held until out_ready
//   out_ready  in   downstream accepts the beat on a clk edge with out_valid
//   out_last   out  marks the final payload beat of a frame
//   frame_done out  one-cycle pulse: frame finished or aborted
//   frame_err  out  with frame_done: frame is bad, discard its beats
//   err_code   out  with frame_done: 0 ok, 1 checksum, 2 length, 3 timeout
// ---------------------------------------------------------------------------
module uart_frame_deframer #(
   parameter int                  DATA_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'hA5,
   parameter int                  MAX_LEN        = 64,
   parameter int                  TIMEOUT_WIDTH  = 16,
   parameter int                  TIMEOUT_CYCLES = 10000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_empty,
   output logic                  rx_read,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [1:0]            err_code
);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'd0;
   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_LEN = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   localparam logic [DATA_WIDTH-1:0]    MAX_LEN_V = DATA_WIDTH'(MAX_LEN);
   // Counter value from which one more empty cycle means the frame has expired.
   localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic                    rx_read_q, rx_read_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    frame_done_q, frame_done_d;
   logic                    frame_err_q, frame_err_d;
   logic [1:0]              err_code_q, err_code_d;
   logic [DATA_WIDTH-1:0]   sum_q, sum_d;
   logic [DATA_WIDTH-1:0]   count_q, count_d;
   logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;

   logic                    accept;
   logic                    capture;
   logic [DATA_WIDTH-1:0]   chk_sum;

   // Next-state and output logic. A byte is taken from the FIFO only when the
   // previous pop has already been issued (rx_read low) so the head word has
   // settled; in PAYLOAD the output register must also be free or retiring.
   always_comb begin
      state_d      = state_q;
      rx_read_d    = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      err_code_d   = err_code_q;
      sum_d        = sum_q;
      count_d      = count_q;
      tmo_d        = tmo_q;

      accept  = (state_q != ST_PAYLOAD) || !out_valid_q || out_ready;
      capture = !rx_empty && !rx_read_q && accept;
      chk_sum = sum_q + rx_data;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (capture) begin
         rx_read_d = 1'b1;
      end

      case (state_q)
         ST_HUNT: begin
            tmo_d = '0;
            if (capture && (rx_data == SYNC_BYTE)) begin
               state_d = ST_LEN;
            end
         end

         ST_LEN: begin
            if (capture) begin
               sum_d = rx_data;
               if (rx_data == '0) begin
                  state_d = ST_CHK;
               end else if (rx_data > MAX_LEN_V) begin
                  frame_done_d = 1'b1;
                  frame_err_d  = 1'b1;
                  err_code_d   = ERR_LEN;
                  state_d      = ST_HUNT;
               end else begin
                  count_d = rx_data;
                  state_d = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            // Loading a new beat overrides the retire above, so a beat
            // handed off on this edge is replaced without a bubble.
            if (capture) begin
               out_data_d  = rx_data;
               out_valid_d = 1'b1;
               out_last_d  = (count_q == DATA_WIDTH'(1));
               sum_d       = sum_q + rx_data;
               count_d     = count_q - DATA_WIDTH'(1);
               if (count_q == DATA_WIDTH'(1)) begin
                  state_d = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            if (capture) begin
               frame_done_d = 1'b1;
               state_d      = ST_HUNT;
               if (chk_sum == '0) begin
                  frame_err_d = 1'b0;
                  err_code_d  = ERR_OK;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
            end
         end

         default: begin
            state_d = ST_HUNT;
         end
      endcase

      // Inter-byte timeout inside a frame. Only an empty FIFO advances the
      // counter, so downstream backpressure can never abort a frame. A pending
      // output beat is left untouched on abort.
      if (state_q != ST_HUNT) begin
         if (capture) begin
            tmo_d = '0;
         end else if (ce && rx_empty) begin
            if (tmo_q >= TMO_LAST) begin
               tmo_d        = '0;
               frame_done_d = 1'b1;
               frame_err_d  = 1'b1;
               err_code_d   = ERR_TMO;
               state_d      = ST_HUNT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
      end
   end

   // State and output registers; reset drops any frame in flight and any
   // pending output beat without reporting status.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_HUNT;
         rx_read_q    <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_OK;
         sum_q        <= '0;
         count_q      <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         rx_read_q    <= rx_read_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         sum_q        <= sum_d;
         count_q      <= count_d;
         tmo_q        <= tmo_d;
      end
   end

   assign rx_read    = rx_read_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_deframer
//
// Directed bench for uart_frame_deframer. A queue stands in for the rx FIFO
// (first-word fall-through, popped on edges where rx_read is high). Every
// negative edge the bench logs pops, accepted output beats and status pulses,
// then each scenario compares the log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_frame_deframer;

   logic       clk;
   logic       rst;
   logic       ce;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_read;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;

   logic [7:0] fifo[$];
   logic [8:0] beats[$];

   int checks;
   int errors;
   int cycle_idx;
   int read_cnt;
   int bad_read_cnt;
   int last_read_cycle;
   int done_cnt;
   int done_cycle;
   logic st_err;
   logic [1:0] st_code;

   uart_frame_deframer #(
      .DATA_WIDTH     (8),
      .SYNC_BYTE      (8'hA5),
      .MAX_LEN        (64),
      .TIMEOUT_WIDTH  (16),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .rx_data    (rx_data),
      .rx_empty   (rx_empty),
      .rx_read    (rx_read),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_code   (err_code)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the FIFO read port from the head of the queue.
   task automatic refreshFifo();
      rx_empty = (fifo.size() == 0);
      rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
   endtask

   task automatic pushByte(input logic [7:0] b);
      fifo.push_back(b);
      refreshFifo();
   endtask

   task automatic clearLog();
      beats.delete();
      read_cnt        = 0;
      done_cnt        = 0;
      last_read_cycle = 0;
      done_cycle      = 0;
      st_err          = 1'b0;
      st_code         = 2'd0;
   endtask

   function automatic logic [8:0] beatAt(input int idx);
      if (idx < beats.size()) return beats[idx];
      return 9'h1FF;
   endfunction

   // Advance n clock cycles, logging DUT activity at each negative edge and
   // popping the FIFO just after any edge where rx_read was high.
   task automatic applyStimulus(input int n);
      logic pop_pending;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cycle_idx++;
         pop_pending = rx_read;
         if (rx_read === 1'b1) begin
            read_cnt++;
            last_read_cycle = cycle_idx;
            if (rx_empty) bad_read_cnt++;
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beats.push_back({out_last, out_data});
         end
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle_idx;
            st_err     = frame_err;
            st_code    = err_code;
         end
         @(posedge clk);
         #1;
         if (pop_pending === 1'b1 && fifo.size() > 0) begin
            void'(fifo.pop_front());
         end
         refreshFifo();
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      cycle_idx    = 0;
      bad_read_cnt = 0;
      clearLog();
      rst       = 1'b1;
      ce        = 1'b1;
      out_ready = 1'b1;
      refreshFifo();

      // Reset values.
      applyStimulus(3);
      checkOutput("rst_rx_read",    32'(rx_read),    32'd0);
      checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
      checkOutput("rst_out_last",   32'(out_last),   32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_err",  32'(frame_err),  32'd0);
      checkOutput("rst_out_data",   32'(out_data),   32'd0);
      checkOutput("rst_err_code",   32'(err_code),   32'd0);
      rst = 1'b0;
      applyStimulus(2);

      // Good frame: 03+11+22+33+97 = 0x100.
      $display("[TB] good frame");
      clearLog();
      pushByte(8'hA5); pushByte(8'h03); pushByte(8'h11);
      pushByte(8'h22); pushByte(8'h33); pushByte(8'h97);
      applyStimulus(30);
      checkOutput("t1_nbeats", 32'(beats.size()), 32'd3);
      checkOutput("t1_beat0",  32'(beatAt(0)), 32'h011);
      checkOutput("t1_beat1",  32'(beatAt(1)), 32'h022);
      checkOutput("t1_beat2",  32'(beatAt(2)), 32'h133);
      checkOutput("t1_done",   32'(done_cnt),  32'd1);
      checkOutput("t1_err",    32'(st_err),    32'd0);
      checkOutput("t1_code",   32'(st_code),   32'd0);
      checkOutput("t1_reads",  32'(read_cnt),  32'd6);

      // Bad checksum: sum ends at 0x69.
      $display("[TB] checksum error");
      clearLog();
      pushByte(8'hA5); pushByte(8'h03); pushByte(8'h11);
      pushByte(8'h22); pushByte(8'h33); pushByte(8'h00);
      applyStimulus(30);
      checkOutput("t2_nbeats", 32'(beats.size()), 32'd3);
      checkOutput("t2_beat2",  32'(beatAt(2)), 32'h133);
      checkOutput("t2_done",   32'(done_cnt),  32'd1);
      checkOutput("t2_err",    32'(st_err),    32'd1);
      checkOutput("t2_code",   32'(st_code),   32'd1);

      // Junk before sync is dropped silently: 01+7E+81 = 0x100.
      $display("[TB] hunt drops junk");
      clearLog();
      pushByte(8'h00); pushByte(8'hFF); pushByte(8'h5A);
      pushByte(8'hA5); pushByte(8'h01); pushByte(8'h7E); pushByte(8'h81);
      applyStimulus(30);
      checkOutput("t3_nbeats", 32'(beats.size()), 32'd1);
      checkOutput("t3_beat0",  32'(beatAt(0)), 32'h17E);
      checkOutput("t3_done",   32'(done_cnt),  32'd1);
      checkOutput("t3_code",   32'(st_code),   32'd0);
      checkOutput("t3_reads",  32'(read_cnt),  32'd7);

      // Length 0x50 exceeds 64; then a zero-length frame.
      $display("[TB] length error and empty frame");
      clearLog();
      pushByte(8'hA5); pushByte(8'h50);
      applyStimulus(12);
      checkOutput("t4_len_done", 32'(done_cnt), 32'd1);
      checkOutput("t4_len_err",  32'(st_err),   32'd1);
      checkOutput("t4_len_code", 32'(st_code),  32'd2);
      clearLog();
      pushByte(8'hA5); pushByte(8'h00); pushByte(8'h00);
      applyStimulus(16);
      checkOutput("t4_zero_done",   32'(done_cnt),      32'd1);
      checkOutput("t4_zero_err",    32'(st_err),        32'd0);
      checkOutput("t4_zero_code",   32'(st_code),       32'd0);
      checkOutput("t4_zero_nbeats", 32'(beats.size()),  32'd0);

      // Timeout: pop cycle after the last byte plus 16 empty cycles.
      $display("[TB] timeout");
      clearLog();
      pushByte(8'hA5); pushByte(8'h02); pushByte(8'h11);
      applyStimulus(40);
      checkOutput("t5_done",    32'(done_cnt), 32'd1);
      checkOutput("t5_err",     32'(st_err),   32'd1);
      checkOutput("t5_code",    32'(st_code),  32'd3);
      checkOutput("t5_latency", 32'(done_cycle - last_read_cycle), 32'd17);
      checkOutput("t5_beat0",   32'(beatAt(0)), 32'h011);

      // Backpressure longer than the timeout: 05+01+02+03+04+05+EC = 0x100.
      $display("[TB] backpressure");
      clearLog();
      out_ready = 1'b0;
      pushByte(8'hA5); pushByte(8'h05); pushByte(8'h01); pushByte(8'h02);
      pushByte(8'h03); pushByte(8'h04); pushByte(8'h05); pushByte(8'hEC);
      applyStimulus(50);
      checkOutput("t6_hold_reads", 32'(read_cnt),  32'd3);
      checkOutput("t6_hold_done",  32'(done_cnt),  32'd0);
      checkOutput("t6_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t6_hold_data",  32'(out_data),  32'h01);
      out_ready = 1'b1;
      applyStimulus(40);
      checkOutput("t6_nbeats", 32'(beats.size()), 32'd5);
      checkOutput("t6_beat0",  32'(beatAt(0)), 32'h001);
      checkOutput("t6_beat3",  32'(beatAt(3)), 32'h004);
      checkOutput("t6_beat4",  32'(beatAt(4)), 32'h105);
      checkOutput("t6_done",   32'(done_cnt),  32'd1);
      checkOutput("t6_code",   32'(st_code),   32'd0);
      checkOutput("t6_reads",  32'(read_cnt),  32'd8);

      // Reset mid-frame with a pending beat: no status, beat dropped.
      $display("[TB] reset mid-frame");
      clearLog();
      out_ready = 1'b0;
      pushByte(8'hA5); pushByte(8'h03); pushByte(8'h11);
      pushByte(8'h22); pushByte(8'h33); pushByte(8'h97);
      applyStimulus(20);
      rst = 1'b1;
      fifo.delete();
      refreshFifo();
      applyStimulus(2);
      rst = 1'b0;
      out_ready = 1'b1;
      applyStimulus(4);
      checkOutput("t7_valid", 32'(out_valid), 32'd0);
      checkOutput("t7_done",  32'(done_cnt),  32'd0);
      pushByte(8'hA5); pushByte(8'h01); pushByte(8'h7E); pushByte(8'h81);
      applyStimulus(20);
      checkOutput("t7_nbeats", 32'(beats.size()), 32'd1);
      checkOutput("t7_beat0",  32'(beatAt(0)), 32'h17E);
      checkOutput("t7_code",   32'(st_code),   32'd0);
      checkOutput("t7_done2",  32'(done_cnt),  32'd1);

      checkOutput("pop_while_empty", 32'(bad_read_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
